// File: rtl/mux_rr_sched_if.sv
// rtl/mux_rr_sched_if.sv - request/grant/mux-control bundle for mux_rr_sched
//
// Purpose: carries the request vector into the scheduler and its grant and
// mux-control outputs back out.
//   req  [7:0] requester -> scheduler, bit i requests mux input i
//   gnt  [7:0] scheduler -> requester, one-hot grant (or zero)
//   sel  [2:0] scheduler -> mux, select index
//   en         scheduler -> mux, enable
//   busy       scheduler -> requester, high whenever the FSM is not IDLE
// Modports: master = request side, slave = scheduler side.
interface mux_rr_sched_if;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       en;
  logic       busy;

  modport master (
    output req,
    input  gnt,
    input  sel,
    input  en,
    input  busy
  );

  modport slave (
    input  req,
    output gnt,
    output sel,
    output en,
    output busy
  );
endinterface

// File: rtl/mux_rr_sched.sv
// rtl/mux_rr_sched.sv - round-robin 8:1 mux scheduler with bounded dwell
//
// Purpose: grants ownership of an 8-input mux to one requester at a time,
// round-robin starting at ptr, for at most DWELL cycles, with a one-cycle
// gap (en=0) between consecutive grants.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   mux_rr_sched_if.slave: req in; gnt, sel, en, busy out (all registered)
// Parameter:
//   DWELL maximum grant length in cycles, 1..15
// Configuration macro:
//   MUX_SCHED_PARK_EN  when defined, IDLE parks the mux (en=1, sel = last
//                      granted index) once a grant has completed.
module mux_rr_sched #(
  parameter int unsigned DWELL = 4
) (
  input  logic           clk,
  input  logic           rst,
  mux_rr_sched_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(DWELL - 1);

  state_t     state_q;
  logic [7:0] gnt_q;
  logic [2:0] sel_q;
  logic [2:0] ptr_q;
  logic [3:0] cnt_q;
  logic       en_q;
  logic       busy_q;

  // Arbitration result for the current cycle and grant-termination flag.
  logic       win_vld_d;
  logic [2:0] win_idx_d;
  logic [2:0] cand_d;
  logic       grant_end_d;
  logic [3:0] cnt_dec_d;

  // First set request at or above ptr, wrapping modulo 8. The 3-bit add
  // provides the wrap for free.
  always_comb begin
    win_vld_d = 1'b0;
    win_idx_d = 3'd0;
    cand_d    = 3'd0;
    for (int k = 0; k < 8; k++) begin
      cand_d = ptr_q + 3'(k);
      if (!win_vld_d && bus.req[cand_d]) begin
        win_vld_d = 1'b1;
        win_idx_d = cand_d;
      end
    end
  end

  // Expiry and release are OR-ed into one flag so a coincident pair yields
  // a single exit to GAP.
  always_comb begin
    grant_end_d = (cnt_q == 4'd0) || !bus.req[sel_q];
    cnt_dec_d   = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= 8'd0;
      sel_q   <= 3'd0;
      ptr_q   <= 3'd0;
      cnt_q   <= 4'd0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_GAP: begin
          if (win_vld_d) begin
            state_q <= ST_GRANT;
            gnt_q   <= 8'd1 << win_idx_d;
            sel_q   <= win_idx_d;
            cnt_q   <= CNT_LOAD;
            en_q    <= 1'b1;
            busy_q  <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            gnt_q   <= 8'd0;
            busy_q  <= 1'b0;
`ifdef MUX_SCHED_PARK_EN
            // IDLE is only reached from GAP after a completed grant or from
            // reset; park only in the former case and hold while idling.
            if (state_q == ST_GAP) begin
              en_q <= 1'b1;
            end
`else
            en_q    <= 1'b0;
`endif
          end
        end

        ST_GRANT: begin
          cnt_q <= cnt_dec_d;
          if (grant_end_d) begin
            state_q <= ST_GAP;
            gnt_q   <= 8'd0;
            en_q    <= 1'b0;
            busy_q  <= 1'b1;
            ptr_q   <= sel_q + 3'd1;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          gnt_q   <= 8'd0;
          en_q    <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.sel  = sel_q;
  assign bus.en   = en_q;
  assign bus.busy = busy_q;

  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (rst)
    $onehot0(gnt_q));

  a_gnt_matches_sel : assert property (@(posedge clk) disable iff (rst)
    (state_q == ST_GRANT) |-> (en_q && (gnt_q == (8'd1 << sel_q))));

  a_busy_state : assert property (@(posedge clk) disable iff (rst)
    busy_q == (state_q != ST_IDLE));

endmodule

// File: tb/tb_mux_rr_sched.sv
// tb/tb_mux_rr_sched.sv - scoreboard bench for mux_rr_sched
module tb_mux_rr_sched;

  localparam int DWELL = 4;
`ifdef MUX_SCHED_PARK_EN
  localparam bit PARK = 1'b1;
`else
  localparam bit PARK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mux_rr_sched_if bus_if();

  mux_rr_sched #(.DWELL(DWELL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Expected {gnt, sel, en, busy} after each clock edge.
  logic [12:0] exp_q[$];

  // Reference model: owner of the mux (-1 = none), number of cycles the
  // current grant has been visible, rotation pointer, last granted index,
  // whether the single gap cycle is showing, and whether the mux is parked.
  int m_owner  = -1;
  int m_held   = 0;
  int m_ptr    = 0;
  int m_last   = 0;
  bit m_gap    = 1'b0;
  bit m_parked = 1'b0;

  function automatic void model_step(input bit r, input logic [7:0] rq);
    logic [7:0] e_gnt;
    logic [2:0] e_sel;
    bit         e_en;
    bit         e_busy;
    bit         was_gap;
    bit         found;
    if (r) begin
      m_owner  = -1;
      m_held   = 0;
      m_ptr    = 0;
      m_last   = 0;
      m_gap    = 1'b0;
      m_parked = 1'b0;
    end else if (m_owner >= 0) begin
      if (m_held >= DWELL || !rq[m_owner]) begin
        m_ptr   = (m_owner + 1) % 8;
        m_owner = -1;
        m_gap   = 1'b1;
      end else begin
        m_held++;
      end
    end else begin
      was_gap = m_gap;
      m_gap   = 1'b0;
      if (rq != 8'd0) begin
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
          if (!found && rq[(m_ptr + k) % 8]) begin
            found   = 1'b1;
            m_owner = (m_ptr + k) % 8;
          end
        end
        m_held   = 1;
        m_last   = m_owner;
        m_parked = 1'b0;
      end else if (was_gap) begin
        m_parked = 1'b1;
      end
    end
    e_gnt  = (m_owner >= 0) ? (8'd1 << m_owner) : 8'd0;
    e_sel  = (m_owner >= 0) ? 3'(m_owner) : 3'(m_last);
    e_en   = (m_owner >= 0) || (PARK && m_parked && !m_gap);
    e_busy = (m_owner >= 0) || m_gap;
    exp_q.push_back({e_gnt, e_sel, e_en, e_busy});
  endfunction

  task automatic cycle(input bit r, input logic [7:0] rq);
    rst        = r;
    bus_if.req = rq;
    model_step(r, rq);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic hold(input bit r, input logic [7:0] rq, input int n);
    for (int i = 0; i < n; i++) cycle(r, rq);
  endtask

  // Monitor: outputs are presented every cycle, so compare on every
  // falling edge that has a pending expectation.
  always @(negedge clk) begin
    logic [12:0] e;
    logic [12:0] a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {bus_if.gnt, bus_if.sel, bus_if.en, bus_if.busy};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL outputs cyc=%0d actual gnt=%h sel=%0d en=%b busy=%b required gnt=%h sel=%0d en=%b busy=%b",
                 cyc, a[12:5], a[4:2], a[1], a[0], e[12:5], e[4:2], e[1], e[0]);
      end
      checks++;
      if (!$onehot0(bus_if.gnt) || (bus_if.gnt != 8'd0 && bus_if.gnt != (8'd1 << bus_if.sel))) begin
        failures++;
        $display("FAIL gnt_onehot_sel cyc=%0d actual gnt=%h sel=%0d required onehot(sel) or 0",
                 cyc, bus_if.gnt, bus_if.sel);
      end
    end
  end

  initial begin
    logic [7:0] rq;
    int         len;
    int         kind;

    hold(1'b1, 8'h00, 3);

    // Single requester: grant, gap, regrant of the same index.
    hold(1'b0, 8'h04, 12);
    hold(1'b0, 8'h00, 3);

    // All requesting: full rotation 0..7 then 0 again.
    hold(1'b1, 8'h00, 1);
    hold(1'b0, 8'hFF, 48);

    // Early release of a single requester.
    hold(1'b1, 8'h00, 1);
    hold(1'b0, 8'h20, 3);
    hold(1'b0, 8'h00, 4);

    // Reset mid-grant of index 3, then arbitration restarts from ptr=0.
    hold(1'b1, 8'h00, 1);
    hold(1'b0, 8'h08, 3);
    hold(1'b1, 8'h08, 1);
    hold(1'b0, 8'h88, 14);

    // Wrap-around from 7 to 0 and back to 7.
    hold(1'b1, 8'h00, 1);
    hold(1'b0, 8'h80, 2);
    hold(1'b0, 8'h81, 16);

    // Grant of 6 ends with no requests: IDLE parking behaviour.
    hold(1'b1, 8'h00, 1);
    hold(1'b0, 8'h40, 3);
    hold(1'b0, 8'h00, 6);

    // Randomised stretches of request patterns with occasional resets.
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 9);
      len  = $urandom_range(1, 12);
      case (kind)
        0:       rq = 8'h00;
        1:       rq = 8'hFF;
        2, 3:    rq = 8'd1 << $urandom_range(0, 7);
        default: rq = 8'($urandom);
      endcase
      if ($urandom_range(0, 39) == 0) hold(1'b1, rq, 1);
      for (int i = 0; i < len; i++) begin
        // Occasionally flip a bit mid-stretch to hit release timing.
        if ($urandom_range(0, 7) == 0) rq[$urandom_range(0, 7)] ^= 1'b1;
        cycle(1'b0, rq);
      end
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual pending=%0d required pending=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_rr_sched.md
MUX_RR_SCHED -- requirements
Module: mux_rr_sched

Interface
REQ-001 The block SHALL have parameter DWELL, default 4, giving the maximum grant length in cycles (legal range 1..15).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all logic is clocked on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-004 The block SHALL have port req, input, 8, one request line per mux data input; bit i requests mux input i.
REQ-005 The block SHALL have port gnt, output, 8, a one-hot grant to the requester currently owning the mux.
REQ-006 The block SHALL have port sel, output, 3, the mux select (x), equal to the index of the granted requester.
REQ-007 The block SHALL have port en, output, 1, the mux enable (EN).
REQ-008 The block SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-009 The block SHALL implement states IDLE, GRANT and GAP with registered outputs only.
REQ-010 Arbitration SHALL be round-robin: pick the first set req bit at or above pointer ptr, searching upward modulo 8 (7 wraps to 0).
REQ-011 In IDLE or GAP, if req is nonzero at edge N, the FSM SHALL enter GRANT at edge N+1 with gnt=onehot(winner), sel=winner, en=1.
REQ-012 In IDLE or GAP, if req is zero, the FSM SHALL enter or stay in IDLE.
REQ-013 On entry to GRANT, dwell counter cnt SHALL load DWELL-1 and decrement by 1 per GRANT cycle, saturating at 0.
REQ-014 GRANT SHALL end at the edge where cnt==0 or req[sel]==0 is sampled, whichever comes first; a coincident expiry and release SHALL yield a single exit.
REQ-015 On leaving GRANT the FSM SHALL enter GAP for exactly one cycle with gnt=0, en=0, sel held, and ptr=(sel+1) mod 8.
REQ-016 At most one gnt bit SHALL ever be set, and while en=1 in GRANT, gnt SHALL equal onehot(sel).
REQ-017 Changes to req during GRANT other than req[sel] SHALL be ignored until the next arbitration.
REQ-018 Maximum grant length SHALL be DWELL cycles, and a continuously requesting port SHALL wait at most 7*(DWELL+1) cycles.

Reset
REQ-019 When rst is high at an edge, state=IDLE, gnt=0, sel=0, en=0, busy=0, ptr=0 and cnt=0 at that edge, including mid-GRANT, overriding all other inputs.
REQ-020 The first arbitration after reset SHALL occur at the first edge with rst low and SHALL use ptr=0.

Configuration
REQ-021 Macro MUX_SCHED_PARK_EN SHALL control IDLE-state parking.
REQ-022 With MUX_SCHED_PARK_EN defined, IDLE SHALL drive en=1 with sel held at the last granted index and gnt=0; en stays 0 after reset until the first grant completes, and GAP still forces en=0.
REQ-023 Without MUX_SCHED_PARK_EN, IDLE SHALL drive en=0.
REQ-024 The macro SHALL change no ports and no timing.

Verification (DWELL=4 unless noted)
REQ-025 Single requester: req=0x04 held from cycle 0 -> gnt=0x04, sel=2, en=1 for cycles 1-4, GAP at cycle 5, regrant of sel=2 at cycle 6.
REQ-026 All request: req=0xFF after reset -> grants sel=0,1,...,7,0 in order, each 4 cycles, separated by 1-cycle GAPs.
REQ-027 Early release: req=0x20, dropped after 2 GRANT cycles -> GAP on the next edge, then IDLE with busy=0 and en=0.
REQ-028 Reset mid-operation: rst pulsed during GRANT of sel=3 -> all outputs 0 on the next edge; then req=0x88 -> first grant is sel=3, not 7.
REQ-029 Wrap-around: grant of sel=7 ends with req=0x81 -> the next grant is sel=0, then sel=7.
REQ-030 PARK build: grant of sel=6 ends and req=0 -> IDLE with en=1, sel=6, gnt=0; the non-PARK build gives en=0.
